// File: rtl/bank_pkg.sv
// bank_pkg: shared dispatcher state type and parameter defaults
package bank_pkg;
    localparam int DEF_DEPTH     = 8;
    localparam int DEF_N_TELLERS = 3;
    localparam int DEF_TICKET_W  = 4;
    localparam int DEF_SVC_TIME  = 5;
    typedef enum logic {IDLE, CALL} state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin pick of one requester, searching upward from ptr
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic [N-1:0] req,
    input  logic [1:0]   ptr,
    output logic [1:0]   grant,
    output logic         valid
);
    logic [3:0] req4;
    logic [2:0] sum;
    assign valid = |req;
    // walk from the farthest slot back to ptr so the nearest requester wins
    always_comb begin
        req4  = 4'(req);
        grant = '0;
        sum   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + 3'(k);
            if (sum >= 3'(N)) sum = sum - 3'(N);
            if (req4[sum[1:0]]) grant = sum[1:0];
        end
    end
endmodule

// File: rtl/queue_dispatcher.sv
// queue_dispatcher: ticket FIFO fed by an entrance sensor, dispatched round-robin to tellers
module queue_dispatcher
    import bank_pkg::*;
#(
    parameter int DEPTH     = DEF_DEPTH,
    parameter int N_TELLERS = DEF_N_TELLERS,
    parameter int TICKET_W  = DEF_TICKET_W,
    parameter int SVC_TIME  = DEF_SVC_TIME
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bph,
    input  logic [N_TELLERS-1:0] teller_free,
    output logic                 call_valid,
    output logic [1:0]           call_teller,
    output logic [TICKET_W-1:0]  call_ticket,
    output logic [3:0]           count,
    output logic                 full,
    output logic                 empty,
    output logic                 drop,
    output logic [7:0]           wait_est
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    logic [TICKET_W-1:0]  mem [DEPTH];
    logic [PW-1:0]        rd_ptr, wr_ptr;
    logic [TICKET_W-1:0]  next_ticket;
    logic [N_TELLERS-1:0] busy;
    logic [1:0]           rr_ptr, grant, grant_q;
    logic                 grant_valid, bph_q, arrival, push, pop;
    logic [15:0]          wait_full;
    state_t               state, state_nxt;

    assign arrival     = bph & ~bph_q;
    assign push        = arrival & ~full;
    assign pop         = (state == CALL) & ~rst;
    assign full        = count == 4'(DEPTH);
    assign empty       = count == 4'd0;
    assign wait_full   = 16'(count) * 16'(SVC_TIME);
    assign wait_est    = wait_full > 16'd255 ? 8'hff : wait_full[7:0];
    assign call_valid  = pop;
    assign call_teller = call_valid ? grant_q : 2'd0;
    assign call_ticket = call_valid ? mem[rd_ptr] : '0;

    rr_arbiter #(.N(N_TELLERS)) u_arb (
        .req   (teller_free & ~busy),
        .ptr   (rr_ptr),
        .grant (grant),
        .valid (grant_valid)
    );

    // a call lasts one cycle, so consecutive calls are at least two cycles apart
    always_comb begin
        state_nxt = (state == CALL) ? IDLE : (!empty && grant_valid) ? CALL : IDLE;
    end

    // state register and the grant captured on entry to CALL
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            grant_q <= '0;
        end else begin
            state   <= state_nxt;
            grant_q <= (state == IDLE && state_nxt == CALL) ? grant : grant_q;
        end
    end

    // ticket storage; contents need no reset since pointers gate every read
    always_ff @(posedge clk) begin
        if (push && !rst) mem[wr_ptr] <= next_ticket;
    end

    // pointers, occupancy, ticket counter and arrival edge history
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            next_ticket <= '0;
            // history reads as high so a level held through reset is not an arrival
            bph_q       <= 1'b1;
            drop        <= 1'b0;
        end else begin
            bph_q <= bph;
            drop  <= arrival & full;
            count <= count + 4'(push) - 4'(pop);
            if (push) begin
                wr_ptr      <= wr_ptr == PW'(DEPTH - 1) ? '0 : wr_ptr + PW'(1);
                next_ticket <= next_ticket + TICKET_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr == PW'(DEPTH - 1) ? '0 : rd_ptr + PW'(1);
        end
    end

    // busy holds a called teller out until it drops free; pointer moves past each grant
    always_ff @(posedge clk) begin
        if (rst) begin
            busy   <= '0;
            rr_ptr <= '0;
        end else begin
            busy <= (busy & teller_free) | (pop ? N_TELLERS'(1) << grant_q : '0);
            if (pop) rr_ptr <= grant_q == 2'(N_TELLERS - 1) ? 2'd0 : grant_q + 2'd1;
        end
    end
endmodule

// File: tb/tb_queue_dispatcher.sv
// tb_queue_dispatcher: directed scoreboard bench for queue_dispatcher
module tb_queue_dispatcher;
    logic       clk = 1'b0, rst = 1'b1, bph = 1'b0;
    logic [2:0] tf = 3'b000;
    logic       call_valid, full, empty, drop;
    logic [1:0] call_teller;
    logic [3:0] call_ticket, count;
    logic [7:0] wait_est;
    int         checks = 0, passed = 0, cyc = 0, last_call = -100;
    logic [3:0] sb[$], called[$];
    logic [1:0] tq[$];
    int         call_cyc[$];
    logic [3:0] tb_next = 4'd0;
    logic       found;

    queue_dispatcher dut (
        .clk(clk), .rst(rst), .bph(bph), .teller_free(tf),
        .call_valid(call_valid), .call_teller(call_teller), .call_ticket(call_ticket),
        .count(count), .full(full), .empty(empty), .drop(drop), .wait_est(wait_est)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic arrive(input logic exp_drop);
        bph = 1'b1;
        tick();
        chk("drop", drop, exp_drop);
        if (!exp_drop) begin
            sb.push_back(tb_next);
            tb_next++;
        end
        bph = 1'b0;
        tick();
        chk("drop_end", drop, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        sb.delete();
        tq.delete();
        tb_next   = 4'd0;
        last_call = -100;
        tick();
    endtask

    always @(negedge clk) begin
        if (call_valid) begin
            chk("call_expected", sb.size() > 0, 1);
            if (sb.size() > 0) chk("call_ticket", call_ticket, sb.pop_front());
            if (tq.size() > 0) chk("call_teller", call_teller, tq.pop_front());
            chk("call_spacing", (cyc - last_call) >= 2, 1);
            last_call = cyc;
            call_cyc.push_back(cyc);
            called.push_back(call_ticket);
        end
    end

    initial begin
        tick();
        chk("rst_call_valid", call_valid, 0);
        chk("rst_drop", drop, 0);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_wait", wait_est, 0);
        chk("rst_teller", call_teller, 0);
        chk("rst_ticket", call_ticket, 0);
        do_reset();

        for (int i = 0; i < 3; i++) arrive(1'b0);
        chk("three_count", count, 3);
        chk("three_empty", empty, 0);
        chk("three_wait", wait_est, 15);
        chk("three_next", dut.next_ticket, 3);
        for (int i = 0; i < 3; i++) chk("stored_ticket", dut.mem[i], i);

        call_cyc.delete();
        tq.push_back(2'd0);
        tq.push_back(2'd1);
        tq.push_back(2'd2);
        tf = 3'b111;
        repeat (12) tick();
        chk("rr_calls", call_cyc.size(), 3);
        if (call_cyc.size() == 3) begin
            chk("rr_gap1", call_cyc[1] - call_cyc[0], 2);
            chk("rr_gap2", call_cyc[2] - call_cyc[1], 2);
        end
        chk("rr_count", count, 0);
        chk("rr_empty", empty, 1);
        chk("rr_sb", sb.size(), 0);
        tf = 3'b000;
        tick();
        chk("busy_clear", dut.busy, 0);

        do_reset();
        for (int i = 0; i < 8; i++) arrive(1'b0);
        chk("full_count", count, 8);
        chk("full_flag", full, 1);
        chk("full_wait", wait_est, 40);
        arrive(1'b1);
        chk("drop_count", count, 8);
        chk("drop_next", dut.next_ticket, 8);

        tq.push_back(2'd0);
        tf = 3'b001;
        tick();
        chk("pop_call", call_valid, 1);
        bph = 1'b1;
        tick();
        chk("popdrop_drop", drop, 1);
        chk("popdrop_count", count, 7);
        chk("popdrop_full", full, 0);
        bph = 1'b0;
        tf  = 3'b000;
        tick();
        chk("popdrop_next", dut.next_ticket, 8);

        for (int i = 0; i < 10; i++) begin
            tf = 3'b000;
            arrive(1'b0);
            chk("wrap_next", dut.next_ticket, tb_next);
            tq.push_back(2'd0);
            tf = 3'b001;
            tick();
            tick();
            tick();
            chk("wrap_count", count, 7);
        end
        tf = 3'b000;
        tick();
        for (int i = 0; i < 40 && sb.size() > 0; i++) begin
            tq.push_back(2'd0);
            tf = 3'b001;
            tick();
            tick();
            tick();
            tf = 3'b000;
            tick();
        end
        chk("drain_count", count, 0);
        chk("drain_sb", sb.size(), 0);
        found = 1'b0;
        for (int k = 0; k + 1 < called.size(); k++)
            if (called[k] == 4'd15) begin
                found = 1'b1;
                chk("wrap_after_15", called[k+1], 0);
            end
        chk("wrap_seen", found, 1);
        tq.delete();

        arrive(1'b0);
        tf = 3'b001;
        tick();
        rst = 1'b1;
        bph = 1'b1;
        #1;
        chk("abort_call_valid", call_valid, 0);
        tick();
        chk("abort_count", count, 0);
        chk("abort_busy", dut.busy, 0);
        chk("abort_valid2", call_valid, 0);
        rst = 1'b0;
        sb.delete();
        tq.delete();
        tb_next = 4'd0;
        repeat (3) tick();
        chk("hold_count", count, 0);
        chk("hold_empty", empty, 1);
        chk("hold_drop", drop, 0);
        chk("hold_next", dut.next_ticket, 0);
        bph = 1'b0;
        tf  = 3'b000;
        tick();
        arrive(1'b0);
        chk("post_count", count, 1);
        tq.push_back(2'd0);
        tf = 3'b001;
        repeat (4) tick();
        chk("post_sb", sb.size(), 0);
        chk("post_empty", empty, 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/queue_dispatcher.md
QUEUE_DISPATCHER -- requirements
Module: queue_dispatcher

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning the maximum number of waiting customers.
REQ-002 The block SHALL have parameter N_TELLERS, default 3, meaning the number of teller windows (2..4).
REQ-003 The block SHALL have parameter TICKET_W, default 4, meaning the ticket number width.
REQ-004 The block SHALL have parameter SVC_TIME, default 5, meaning the per-customer wait estimate in minutes.
REQ-005 clk  in  1  single clock; all logic is rising-edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 bph  in  1  entrance sensor level, synchronous to clk; each rising edge is one arrival.
REQ-008 teller_free  in  N_TELLERS  level per teller: idle and ready for a customer.
REQ-009 call_valid  out  1  one-cycle pulse: ticket called to a teller.
REQ-010 call_teller  out  2  index of the called teller; valid only with call_valid.
REQ-011 call_ticket  out  TICKET_W  called ticket number; valid only with call_valid.
REQ-012 count  out  4  number of customers waiting (0..DEPTH).
REQ-013 full, empty  out  1 each  count==DEPTH and count==0 respectively.
REQ-014 drop  out  1  one-cycle pulse: arrival rejected because the queue is full.
REQ-015 wait_est  out  8  count*SVC_TIME, saturating at 255.

Function
REQ-016 Arrival: the block SHALL register bph and detect a rising edge (bph high and previous bph low); the edge sample is taken in cycle n, and the push/drop effect becomes visible at cycle n+1.
REQ-017 Push: on an arrival with full low, the block SHALL write next_ticket into the FIFO tail and increment next_ticket modulo 2^TICKET_W.
REQ-018 Drop: on an arrival with full high (value before the current update), the block SHALL pulse drop, leave next_ticket unchanged, and accept no entry, even if a pop occurs in the same cycle.
REQ-019 The FIFO SHALL be circular with DEPTH entries and rd/wr pointers wrapping modulo DEPTH.
REQ-020 Eligibility: teller i SHALL be eligible when teller_free[i]=1 and busy[i]=0.
REQ-021 FSM states: IDLE and CALL.
REQ-022 IDLE->CALL SHALL occur when empty=0 and at least one teller is eligible; the grant is registered.
REQ-023 CALL->IDLE SHALL always occur after exactly one cycle.
REQ-024 In CALL, the block SHALL assert call_valid with the head ticket and the granted teller, pop the FIFO, and set busy[granted].
REQ-025 Minimum spacing between consecutive call_valid pulses SHALL be 2 cycles.
REQ-026 busy[i] SHALL clear on the first cycle teller_free[i] is sampled low; a teller held high after a call is never re-called.
REQ-027 Arbitration SHALL be round-robin: a priority pointer starts at teller 0, search is ascending from the pointer, and after a grant to i the pointer becomes (i+1) mod N_TELLERS.
REQ-028 Push and pop in the same cycle SHALL leave count unchanged and both SHALL take effect.
REQ-029 count SHALL never exceed DEPTH or underflow; no pop SHALL occur when empty.
REQ-030 full, empty and wait_est SHALL be derived combinationally from the registered count.

Reset
REQ-031 On rst=1 at a clock edge, the block SHALL clear count, pointers, next_ticket, busy, the priority pointer and the bph history register.
REQ-032 On reset, the FSM SHALL go to IDLE and call_valid and drop SHALL be forced to 0.
REQ-033 Reset values SHALL be: call_teller=0, call_ticket=0, empty=1, full=0, wait_est=0.
REQ-034 Reset mid-CALL SHALL abort the call with no pop, and rst SHALL take priority over every other input.
REQ-035 An asserted bph at reset release SHALL NOT count as an arrival.

Structure
REQ-036 A shared package bank_pkg SHALL hold the FSM state typedef (IDLE, CALL) and the defaults for DEPTH, N_TELLERS, TICKET_W and SVC_TIME.
REQ-037 The round-robin arbiter SHALL be a sub-module rr_arbiter (req, pointer -> grant index, grant valid); the FIFO SHALL stay inline.

Verification
REQ-038 The bench SHALL cover: reset, then 3 bph pulses -> count=3, empty=0, wait_est=15, tickets 0,1,2 stored.
REQ-039 The bench SHALL cover: 3 waiting, teller_free=3'b111 held -> calls to tellers 0,1,2 with tickets 0,1,2, 2 cycles apart; no fourth call while all three stay high; count=0.
REQ-040 The bench SHALL cover: 9 arrivals with no tellers free -> count=8, full=1, ninth arrival gives a drop pulse, next_ticket=8.
REQ-041 The bench SHALL cover: full queue, arrival edge in the same cycle as a CALL pop -> drop=1, count=7.
REQ-042 The bench SHALL cover: 17 accepted tickets with dispatching interleaved -> ticket after 15 is 0 (wrap).
REQ-043 The bench SHALL cover: rst during the CALL cycle -> call_valid=0, count=0, busy=0, and bph held high across reset causes no arrival.
